// File: rtl/lsb_embedder_multi_pkg.sv
// Shared definitions for the multi-channel LSB embedder: FSM encoding and
// parameter legality checks evaluated at elaboration.
package lsb_embedder_multi_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_EMBED = 2'b10
    } state_t;

    localparam int NLSB_MIN = 1;
    localparam int NLSB_MAX = 4;

    function automatic bit nlsb_legal(input int nlsb, input int bps);
        return (nlsb >= NLSB_MIN) && (nlsb <= NLSB_MAX) && (nlsb < bps);
    endfunction

    // A word must split into a whole number of frames.
    function automatic bit k_divides_msg(input int msg_w, input int k);
        return (k > 0) && ((msg_w % k) == 0);
    endfunction

endpackage

// File: rtl/lsb_embedder_multi_insert.sv
// Combinational LSB replacement for a single sample: low NLSB bits are
// overwritten, the rest pass through.
module lsb_insert
    import lsb_embedder_multi_pkg::*;
#(
    parameter int BPS  = 24,
    parameter int NLSB = 1
) (
    input  logic [BPS-1:0]  sample,
    input  logic [NLSB-1:0] bits,
    output logic [BPS-1:0]  result
);

    assign result = {sample[BPS-1:NLSB], bits};

endmodule

// File: rtl/lsb_embedder_multi.sv
// Stream LSB steganography embedder: buffers one message word and spreads it
// MSB-first over the low bits of every channel, one registered cycle of latency.
module lsb_embedder_multi
    import lsb_embedder_multi_pkg::*;
#(
    parameter int BPS      = 24,
    parameter int CHANNELS = 2,
    parameter int NLSB     = 1,
    parameter int MSG_W    = 8
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_enable,
    input  logic                     in_valid,
    input  logic [CHANNELS*BPS-1:0]  in_frame,
    input  logic [MSG_W-1:0]         in_msg_data,
    input  logic                     in_msg_valid,
    output logic                     out_msg_ready,
    output logic [CHANNELS*BPS-1:0]  out_frame,
    output logic                     out_valid,
    output logic                     out_embedded,
    output logic                     out_underrun,
    output logic [31:0]              out_bit_count
);

    localparam int K     = CHANNELS * NLSB;
    localparam int CNT_W = $clog2(MSG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MSG_W);
    localparam logic [CNT_W-1:0] CNT_K    = CNT_W'(K);

    generate
        if (!nlsb_legal(NLSB, BPS)) begin : g_bad_nlsb
            $error("lsb_embedder_multi: NLSB must be 1..4 and below BPS");
        end
        if (!k_divides_msg(MSG_W, K)) begin : g_bad_k
            $error("lsb_embedder_multi: MSG_W must be a multiple of CHANNELS*NLSB");
        end
    endgenerate

    state_t                    state_reg, state_next;
    logic [MSG_W-1:0]          sr_reg, sr_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [CHANNELS*BPS-1:0]   frame_reg, frame_next;
    logic                      valid_reg, valid_next;
    logic                      embedded_reg, embedded_next;
    logic                      underrun_reg, underrun_next;
    logic [31:0]               bit_count_reg, bit_count_next;
    logic [CHANNELS*BPS-1:0]   embedded_frame;

    // Channel gi takes the gi-th NLSB-wide slice counted from the word's MSB.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            lsb_insert #(
                .BPS  (BPS),
                .NLSB (NLSB)
            ) u_insert (
                .sample (in_frame[gi*BPS +: BPS]),
                .bits   (sr_reg[MSG_W-1-gi*NLSB -: NLSB]),
                .result (embedded_frame[gi*BPS +: BPS])
            );
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        sr_next        = sr_reg;
        cnt_next       = cnt_reg;
        frame_next     = frame_reg;
        valid_next     = 1'b0;
        embedded_next  = 1'b0;
        underrun_next  = 1'b0;
        bit_count_next = bit_count_reg;

        if (!in_enable) begin
            // sr keeps its stale contents; cnt=0 marks it invalid.
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (in_valid) begin
                        frame_next    = in_frame;
                        valid_next    = 1'b1;
                        underrun_next = 1'b1;
                    end
                    // A word loaded alongside a frame is first used by the next frame.
                    if (in_msg_valid) begin
                        sr_next    = in_msg_data;
                        cnt_next   = CNT_FULL;
                        state_next = S_EMBED;
                    end
                end
                S_EMBED: begin
                    if (in_valid) begin
                        frame_next     = embedded_frame;
                        valid_next     = 1'b1;
                        embedded_next  = 1'b1;
                        sr_next        = sr_reg << K;
                        cnt_next       = cnt_reg - CNT_K;
                        bit_count_next = bit_count_reg + 32'(K);
                        if (cnt_reg == CNT_K) begin
                            state_next = S_WAIT;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_reg     <= S_IDLE;
            sr_reg        <= '0;
            cnt_reg       <= '0;
            frame_reg     <= '0;
            valid_reg     <= 1'b0;
            embedded_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            bit_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            cnt_reg       <= cnt_next;
            frame_reg     <= frame_next;
            valid_reg     <= valid_next;
            embedded_reg  <= embedded_next;
            underrun_reg  <= underrun_next;
            bit_count_reg <= bit_count_next;
        end
    end

    assign out_msg_ready = (state_reg == S_WAIT);
    assign out_frame     = frame_reg;
    assign out_valid     = valid_reg;
    assign out_embedded  = embedded_reg;
    assign out_underrun  = underrun_reg;
    assign out_bit_count = bit_count_reg;

endmodule

// File: tb/tb_lsb_embedder_multi.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// bit-queue reference model; a second instance covers NLSB=2, one channel.
`timescale 1ns/1ps
module tb_lsb_embedder_multi;

    localparam int NLSB = 1;
    localparam int K    = 2 * NLSB;
    localparam logic [47:0] ALL1 = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // default instance
    logic        en = 1'b0, v = 1'b0, mv = 1'b0;
    logic [47:0] frame = '0;
    logic [7:0]  md = '0;
    logic        ready, out_valid, out_emb, out_und;
    logic [47:0] out_frame;
    logic [31:0] count;

    // NLSB=2, single-channel instance
    logic        en2 = 1'b0, v2 = 1'b0, mv2 = 1'b0;
    logic [23:0] frame2 = '0;
    logic [7:0]  md2 = '0;
    logic        ready2, out_valid2, out_emb2, out_und2;
    logic [23:0] out_frame2;
    logic [31:0] count2;

    int checks = 0;
    int failures = 0;

    // reference model: the buffer is just the queue of unconsumed message bits
    bit          mq[$];
    bit          m_active = 1'b0;
    logic [47:0] m_frame = '0;
    logic [31:0] m_count = '0;

    always #5 clk = ~clk;

    lsb_embedder_multi #(.BPS(24), .CHANNELS(2), .NLSB(NLSB), .MSG_W(8)) dut (
        .in_clk(clk), .in_rst(rst), .in_enable(en), .in_valid(v),
        .in_frame(frame), .in_msg_data(md), .in_msg_valid(mv),
        .out_msg_ready(ready), .out_frame(out_frame), .out_valid(out_valid),
        .out_embedded(out_emb), .out_underrun(out_und), .out_bit_count(count)
    );

    lsb_embedder_multi #(.BPS(24), .CHANNELS(1), .NLSB(2), .MSG_W(8)) dut2 (
        .in_clk(clk), .in_rst(rst), .in_enable(en2), .in_valid(v2),
        .in_frame(frame2), .in_msg_data(md2), .in_msg_valid(mv2),
        .out_msg_ready(ready2), .out_frame(out_frame2), .out_valid(out_valid2),
        .out_embedded(out_emb2), .out_underrun(out_und2), .out_bit_count(count2)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_frame  = '0;
        m_count  = '0;
    endtask

    // One clock of traffic on the default instance, checked against the model.
    task automatic step(input logic en_i, input logic v_i, input logic [47:0] f_i,
                        input logic mv_i, input logic [7:0] md_i);
        logic e_valid, e_emb, e_und, e_ready;
        e_valid = 1'b0; e_emb = 1'b0; e_und = 1'b0;
        @(negedge clk);
        en = en_i; v = v_i; frame = f_i; mv = mv_i; md = md_i;
        if (!en_i) begin
            m_active = 1'b0;
            mq.delete();
        end else if (!m_active) begin
            m_active = 1'b1;
        end else if (mq.size() == 0) begin
            if (v_i) begin
                e_valid = 1'b1; e_und = 1'b1; m_frame = f_i;
            end
            if (mv_i) begin
                for (int b = 7; b >= 0; b--) mq.push_back(md_i[b]);
            end
        end else if (v_i) begin
            e_valid = 1'b1; e_emb = 1'b1; m_frame = f_i;
            for (int c = 0; c < 2; c++) begin
                for (int j = NLSB - 1; j >= 0; j--) m_frame[c*24 + j] = mq.pop_front();
            end
            m_count = m_count + 32'(K);
        end
        e_ready = m_active && (mq.size() == 0);
        @(posedge clk);
        #1;
        check_val("valid", {63'd0, out_valid}, {63'd0, e_valid});
        check_val("embedded", {63'd0, out_emb}, {63'd0, e_emb});
        check_val("underrun", {63'd0, out_und}, {63'd0, e_und});
        check_val("msg_ready", {63'd0, ready}, {63'd0, e_ready});
        check_val("frame", {16'd0, out_frame}, {16'd0, m_frame});
        check_val("bit_count", {32'd0, count}, {32'd0, m_count});
        if (out_valid)
            $display("frame out=%012h emb=%0b und=%0b count=%0d", out_frame, out_emb, out_und, count);
    endtask

    initial begin
        logic [1:0]  pairs [4];
        logic [23:0] exp2;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_frame", {16'd0, out_frame}, 64'd0);
        check_val("rst_ready", {63'd0, ready}, 64'd0);
        check_val("rst_count", {32'd0, count}, 64'd0);

        // A5 over four all-ones frames
        step(1, 0, '0, 0, 8'h00);
        check_val("idle_to_wait_ready", {63'd0, ready}, 64'd1);
        step(1, 0, '0, 1, 8'hA5);
        check_val("loaded_ready_low", {63'd0, ready}, 64'd0);
        step(1, 1, ALL1, 0, 8'h00);
        check_val("a5_f0", {16'd0, out_frame}, {16'd0, 48'hFFFFFE_FFFFFF});
        step(1, 1, ALL1, 0, 8'h00);
        check_val("a5_f1", {16'd0, out_frame}, {16'd0, 48'hFFFFFE_FFFFFF});
        step(1, 1, ALL1, 0, 8'h00);
        check_val("a5_f2", {16'd0, out_frame}, {16'd0, 48'hFFFFFF_FFFFFE});
        step(1, 1, ALL1, 0, 8'h00);
        check_val("a5_f3", {16'd0, out_frame}, {16'd0, 48'hFFFFFF_FFFFFE});
        check_val("a5_count", {32'd0, count}, 64'd8);
        check_val("a5_back_to_wait", {63'd0, ready}, 64'd1);

        // underrun pass-through
        step(1, 1, 48'h123456_789ABC, 0, 8'h00);
        check_val("ur_frame", {16'd0, out_frame}, {16'd0, 48'h123456_789ABC});
        check_val("ur_flag", {63'd0, out_und}, 64'd1);
        check_val("ur_count", {32'd0, count}, 64'd8);

        // load and frame in the same WAIT cycle
        step(1, 1, '0, 1, 8'hC3);
        check_val("ldfr_underrun", {63'd0, out_und}, 64'd1);
        check_val("ldfr_emb", {63'd0, out_emb}, 64'd0);
        step(1, 1, '0, 0, 8'h00);
        check_val("ldfr_first_bits", {16'd0, out_frame}, {16'd0, 48'h000001_000001});
        repeat (3) step(1, 1, '0, 0, 8'h00);
        check_val("ldfr_count", {32'd0, count}, 64'd16);

        // async reset between edges while a strobe is on the outputs
        step(1, 0, '0, 1, 8'h5A);
        step(1, 1, ALL1, 0, 8'h00);
        #2 rst = 1'b1;
        #1;
        check_val("arst_valid", {63'd0, out_valid}, 64'd0);
        check_val("arst_emb", {63'd0, out_emb}, 64'd0);
        check_val("arst_frame", {16'd0, out_frame}, 64'd0);
        check_val("arst_count", {32'd0, count}, 64'd0);
        check_val("arst_ready", {63'd0, ready}, 64'd0);
        rst = 1'b0;
        model_reset();
        step(1, 1, ALL1, 0, 8'h00);
        check_val("arst_idle_no_out", {63'd0, out_valid}, 64'd0);

        // enable drop after two of four frames
        step(1, 0, '0, 1, 8'hF0);
        step(1, 1, ALL1, 0, 8'h00);
        step(1, 1, ALL1, 0, 8'h00);
        step(0, 1, ALL1, 0, 8'h00);
        check_val("dis_no_out", {63'd0, out_valid}, 64'd0);
        step(0, 1, ALL1, 1, 8'h33);
        check_val("dis_no_out2", {63'd0, out_valid}, 64'd0);
        step(1, 1, ALL1, 0, 8'h00);
        check_val("reen_idle_no_out", {63'd0, out_valid}, 64'd0);
        step(1, 1, 48'hABCDEF_012345, 0, 8'h00);
        check_val("reen_underrun", {63'd0, out_und}, 64'd1);
        check_val("reen_count", {32'd0, count}, 64'd4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) != 0, 1'($urandom), {16'($urandom), 32'($urandom)},
                 $urandom_range(0, 3) == 0, 8'($urandom));
        end

        // NLSB=2, CHANNELS=1 instance
        pairs[0] = 2'b11; pairs[1] = 2'b00; pairs[2] = 2'b10; pairs[3] = 2'b01;
        @(negedge clk);
        en2 = 1'b1;
        @(posedge clk); #1;
        check_val("n2_ready_wait", {63'd0, ready2}, 64'd1);
        @(negedge clk);
        mv2 = 1'b1; md2 = 8'b11_00_10_01;
        @(posedge clk); #1;
        check_val("n2_ready_loaded", {63'd0, ready2}, 64'd0);
        @(negedge clk);
        mv2 = 1'b0; v2 = 1'b1; frame2 = 24'h5A5A5A;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp2 = 24'h5A5A5A;
            exp2[1:0] = pairs[i];
            check_val("n2_frame", {40'd0, out_frame2}, {40'd0, exp2});
            check_val("n2_emb", {63'd0, out_emb2}, 64'd1);
            check_val("n2_ready", {63'd0, ready2}, (i == 3) ? 64'd1 : 64'd0);
            $display("n2 frame out=%06h count=%0d", out_frame2, count2);
            @(negedge clk);
            if (i == 3) v2 = 1'b0;
        end
        check_val("n2_count", {32'd0, count2}, 64'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
